reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp_if.sv | 34 +++
 rtl/reg_file_mp.sv | 134 +++++++++++++
 tb/tb_reg_file_mp.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// Bus bundle for the dual-write / dual-read register file with scrub.
// The master drives writes, read addresses and scrub requests; the slave
// (the register file) returns read data and the scrub-busy flag.
interface reg_file_mp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              WE0;
    logic [ADDR_W-1:0] WADDR0;
    logic [DATA_W-1:0] WDATA0;
    logic              WE1;
    logic [ADDR_W-1:0] WADDR1;
    logic [DATA_W-1:0] WDATA1;
    logic [ADDR_W-1:0] RADDR1;
    logic [ADDR_W-1:0] RADDR2;
    logic [DATA_W-1:0] OUT1;
    logic [DATA_W-1:0] OUT2;
    logic              CLEAR_REQ;
    logic              BUSY;

    modport master (
        output WE0, WADDR0, WDATA0,
        output WE1, WADDR1, WDATA1,
        output RADDR1, RADDR2, CLEAR_REQ,
        input  OUT1, OUT2, BUSY
    );

    modport slave (
        input  WE0, WADDR0, WDATA0,
        input  WE1, WADDR1, WDATA1,
        input  RADDR1, RADDR2, CLEAR_REQ,
        output OUT1, OUT2, BUSY
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, two combinational read ports,
// optional write-to-read forwarding, optional hard-wired zero register and
// a sequential scrub engine that zeroes one register per cycle.
module reg_file_mp #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input logic         CLK,
    input logic         RESET,
    reg_file_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        CLEARING
    } state_e;

    state_e            state_q;
    logic              busy_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic              last_idx;
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic              wr0_ok;
    logic              wr1_ok;
    logic              wr0_store;
    logic [DATA_W-1:0] rd1_val;
    logic [DATA_W-1:0] rd2_val;

    // Write qualification: no writes while scrubbing, and register 0 is
    // read-only when it is hard-wired to zero.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every output a
        // default first, so no latch is inferred.
        wr0_ok    = 1'b0;
        wr1_ok    = 1'b0;
        wr0_store = 1'b0;
        if (!busy_q) begin
            wr0_ok = bus.WE0 && !((ZERO_R0 != 0) && (bus.WADDR0 == '0));
            wr1_ok = bus.WE1 && !((ZERO_R0 != 0) && (bus.WADDR1 == '0));
        end
        // On an address collision port 1 wins; port 0 is simply not stored.
        wr0_store = wr0_ok && !(wr1_ok && (bus.WADDR1 == bus.WADDR0));
    end

    // Scrub index advance and end-of-sweep detection.
    always_comb begin
        idx_d    = idx_q + ADDR_W'(1);
        last_idx = (idx_q == ADDR_W'(DEPTH - 1));
    end

    // Register array, scrub FSM and registered BUSY flag.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state is assigned with non-blocking '<=' only.
        if (RESET) begin
            // NOTE: the storage is a bank of flops that must read zero after
            // reset, so every entry is cleared here rather than left unreset.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr0_store) begin
                        regs_q[bus.WADDR0] <= bus.WDATA0;
                    end
                    if (wr1_ok) begin
                        regs_q[bus.WADDR1] <= bus.WDATA1;
                    end
                    if (bus.CLEAR_REQ) begin
                        state_q <= CLEARING;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                CLEARING: begin
                    regs_q[idx_q] <= '0;
                    idx_q         <= idx_d;
                    if (last_idx) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    // Read port 1: stored value, optionally overridden by a pending write.
    always_comb begin
        rd1_val = regs_q[bus.RADDR1];
        if (BYPASS != 0) begin
            if (wr1_ok && (bus.WADDR1 == bus.RADDR1)) begin
                rd1_val = bus.WDATA1;
            end else if (wr0_ok && (bus.WADDR0 == bus.RADDR1)) begin
                rd1_val = bus.WDATA0;
            end
        end
        if ((ZERO_R0 != 0) && (bus.RADDR1 == '0)) begin
            rd1_val = '0;
        end
    end

    // Read port 2: same forwarding and zero-register rules as port 1.
    always_comb begin
        rd2_val = regs_q[bus.RADDR2];
        if (BYPASS != 0) begin
            if (wr1_ok && (bus.WADDR1 == bus.RADDR2)) begin
                rd2_val = bus.WDATA1;
            end else if (wr0_ok && (bus.WADDR0 == bus.RADDR2)) begin
                rd2_val = bus.WDATA0;
            end
        end
        if ((ZERO_R0 != 0) && (bus.RADDR2 == '0)) begin
            rd2_val = '0;
        end
    end

    assign bus.OUT1 = rd1_val;
    assign bus.OUT2 = rd2_val;
    assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three instances with different parameter sets share
// one stimulus stream and are compared every cycle against an array model.
module tb_reg_file_mp;
    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    // Shared stimulus, sized for the widest instance.
    logic        we0, we1, clear_req;
    logic [3:0]  waddr0, waddr1, raddr1, raddr2;
    logic [15:0] wdata0, wdata1;

    // inst0: 8x8, bypass, no zero reg. inst1: 8x8, bypass, zero reg.
    // inst2: 16x16, no bypass, no zero reg.
    reg_file_mp_if #(.DATA_W(8),  .ADDR_W(3)) bus0 ();
    reg_file_mp_if #(.DATA_W(8),  .ADDR_W(3)) bus1 ();
    reg_file_mp_if #(.DATA_W(16), .ADDR_W(4)) bus2 ();

    assign bus0.WE0 = we0;  assign bus0.WE1 = we1;  assign bus0.CLEAR_REQ = clear_req;
    assign bus0.WADDR0 = waddr0[2:0]; assign bus0.WADDR1 = waddr1[2:0];
    assign bus0.WDATA0 = wdata0[7:0]; assign bus0.WDATA1 = wdata1[7:0];
    assign bus0.RADDR1 = raddr1[2:0]; assign bus0.RADDR2 = raddr2[2:0];

    assign bus1.WE0 = we0;  assign bus1.WE1 = we1;  assign bus1.CLEAR_REQ = clear_req;
    assign bus1.WADDR0 = waddr0[2:0]; assign bus1.WADDR1 = waddr1[2:0];
    assign bus1.WDATA0 = wdata0[7:0]; assign bus1.WDATA1 = wdata1[7:0];
    assign bus1.RADDR1 = raddr1[2:0]; assign bus1.RADDR2 = raddr2[2:0];

    assign bus2.WE0 = we0;  assign bus2.WE1 = we1;  assign bus2.CLEAR_REQ = clear_req;
    assign bus2.WADDR0 = waddr0; assign bus2.WADDR1 = waddr1;
    assign bus2.WDATA0 = wdata0; assign bus2.WDATA1 = wdata1;
    assign bus2.RADDR1 = raddr1; assign bus2.RADDR2 = raddr2;

    reg_file_mp #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_R0(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .bus(bus0));
    reg_file_mp #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_R0(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .bus(bus1));
    reg_file_mp #(.DATA_W(16), .ADDR_W(4), .BYPASS(0), .ZERO_R0(0)) dut2 (
        .CLK(CLK), .RESET(RESET), .bus(bus2));

    // Reference model: plain arrays plus a "scrub in progress" flag/position.
    logic [15:0] mdl_mem [3][16];
    bit          mdl_busy [3];
    int          mdl_pos  [3];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int depth_of(input int i);
        return (i == 2) ? 16 : 8;
    endfunction

    function automatic logic [15:0] dmask_of(input int i);
        return (i == 2) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic bit bypass_of(input int i);
        return (i != 2);
    endfunction

    function automatic bit zero_of(input int i);
        return (i == 1);
    endfunction

    function automatic int amask(input int i, input logic [3:0] a);
        return int'(a) % depth_of(i);
    endfunction

    // Value a read port should show right now, given current inputs.
    function automatic logic [15:0] exp_read(input int i, input logic [3:0] ra);
        int a;
        a = amask(i, ra);
        if (zero_of(i) && a == 0) return 16'h0;
        if (bypass_of(i) && !mdl_busy[i]) begin
            if (we1 && amask(i, waddr1) == a) return wdata1 & dmask_of(i);
            if (we0 && amask(i, waddr0) == a) return wdata0 & dmask_of(i);
        end
        return mdl_mem[i][a];
    endfunction

    // Effect of one rising edge on instance i.
    task automatic model_edge(input int i);
        if (RESET) begin
            for (int k = 0; k < 16; k++) mdl_mem[i][k] = 16'h0;
            mdl_busy[i] = 1'b0;
            mdl_pos[i]  = 0;
        end else if (mdl_busy[i]) begin
            mdl_mem[i][mdl_pos[i]] = 16'h0;
            mdl_pos[i] = mdl_pos[i] + 1;
            if (mdl_pos[i] == depth_of(i)) mdl_busy[i] = 1'b0;
        end else begin
            // Port 1 is applied last so it wins on a collision.
            if (we0 && !(zero_of(i) && amask(i, waddr0) == 0))
                mdl_mem[i][amask(i, waddr0)] = wdata0 & dmask_of(i);
            if (we1 && !(zero_of(i) && amask(i, waddr1) == 0))
                mdl_mem[i][amask(i, waddr1)] = wdata1 & dmask_of(i);
            if (clear_req) begin
                mdl_busy[i] = 1'b1;
                mdl_pos[i]  = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare all outputs, then advance one clock and the model with it.
    task automatic step(input string phase);
        #1;
        check({phase, " i0 OUT1"}, {8'h0, bus0.OUT1}, exp_read(0, raddr1));
        check({phase, " i0 OUT2"}, {8'h0, bus0.OUT2}, exp_read(0, raddr2));
        check({phase, " i0 BUSY"}, {15'h0, bus0.BUSY}, {15'h0, mdl_busy[0]});
        check({phase, " i1 OUT1"}, {8'h0, bus1.OUT1}, exp_read(1, raddr1));
        check({phase, " i1 OUT2"}, {8'h0, bus1.OUT2}, exp_read(1, raddr2));
        check({phase, " i1 BUSY"}, {15'h0, bus1.BUSY}, {15'h0, mdl_busy[1]});
        check({phase, " i2 OUT1"}, bus2.OUT1, exp_read(2, raddr1));
        check({phase, " i2 OUT2"}, bus2.OUT2, exp_read(2, raddr2));
        check({phase, " i2 BUSY"}, {15'h0, bus2.BUSY}, {15'h0, mdl_busy[2]});
        @(posedge CLK);
        for (int i = 0; i < 3; i++) model_edge(i);
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; we1 = 1'b0; clear_req = 1'b0; RESET = 1'b0;
    endtask

    task automatic write0(input logic [3:0] a, input logic [15:0] d);
        we0 = 1'b1; waddr0 = a; wdata0 = d;
    endtask

    task automatic write1(input logic [3:0] a, input logic [15:0] d);
        we1 = 1'b1; waddr1 = a; wdata1 = d;
    endtask

    initial begin
        idle_inputs();
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        raddr1 = '0; raddr2 = '0;
        for (int i = 0; i < 3; i++) begin
            mdl_busy[i] = 1'b0;
            mdl_pos[i]  = 0;
            for (int k = 0; k < 16; k++) mdl_mem[i][k] = 16'h0;
        end

        // Initial reset edge: storage is unknown before it, so no checks.
        RESET = 1'b1;
        @(posedge CLK);
        for (int i = 0; i < 3; i++) model_edge(i);
        @(negedge CLK);
        step("reset");
        RESET = 1'b0;
        raddr1 = 4'd5; raddr2 = 4'd12;
        step("post-reset");

        // Write 0xF0 to r0; forwarded in the write cycle where bypass exists.
        write0(4'd0, 16'h00F0); raddr1 = 4'd0; raddr2 = 4'd1;
        step("r0 write");
        idle_inputs();
        step("r0 read");

        // Same-address collision, then two independent writes.
        write0(4'd3, 16'h0011); write1(4'd3, 16'h0022); raddr1 = 4'd3; raddr2 = 4'd3;
        step("collide");
        write0(4'd2, 16'h000F); write1(4'd5, 16'h00A5); raddr1 = 4'd2; raddr2 = 4'd5;
        step("dual write");
        idle_inputs();
        step("dual read");

        // Fill r0..r7 with 1..8, scrub, and try to write during the scrub.
        for (int k = 0; k < 8; k++) begin
            write0(4'(k), 16'(k + 1)); raddr1 = 4'(k); raddr2 = 4'(7 - k);
            step("fill");
        end
        idle_inputs();
        clear_req = 1'b1;
        step("scrub start");
        clear_req = 1'b0;
        for (int c = 0; c < 18; c++) begin
            write0(4'($urandom_range(0, 15)), 16'($urandom));
            write1(4'(c), 16'hFFFF);
            raddr1 = 4'(c % 8); raddr2 = 4'($urandom_range(0, 15));
            step("scrub");
        end
        idle_inputs();

        // Reset in the middle of a scrub.
        for (int k = 0; k < 8; k++) begin
            write0(4'(k), 16'(k + 1)); write1(4'(k + 8), 16'(16'hBE00 + k));
            step("refill");
        end
        idle_inputs();
        clear_req = 1'b1;
        step("scrub2 start");
        clear_req = 1'b0;
        for (int c = 0; c < 3; c++) step("scrub2");
        RESET = 1'b1;
        step("scrub2 reset");
        RESET = 1'b0;
        for (int k = 0; k < 8; k++) begin
            raddr1 = 4'(k); raddr2 = 4'(k + 8);
            step("after abort");
        end

        // Wide-instance boundary: r15 = 0xBEEF read on both ports.
        write0(4'd15, 16'hBEEF); raddr1 = 4'd15; raddr2 = 4'd15;
        step("r15 write");
        idle_inputs();
        step("r15 read");

        // CLEAR_REQ held high: scrubs restart back to back.
        clear_req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            raddr1 = 4'($urandom_range(0, 15)); raddr2 = 4'd15;
            step("held clear");
        end
        idle_inputs();

        // Randomized traffic, with occasional scrub requests and resets.
        for (int c = 0; c < 400; c++) begin
            we0 = 1'($urandom); waddr0 = 4'($urandom); wdata0 = 16'($urandom);
            we1 = 1'($urandom); waddr1 = 4'($urandom); wdata1 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) waddr1 = waddr0;
            raddr1 = ($urandom_range(0, 2) == 0) ? waddr0 : 4'($urandom);
            raddr2 = ($urandom_range(0, 2) == 0) ? waddr1 : 4'($urandom);
            clear_req = ($urandom_range(0, 24) == 0);
            RESET     = ($urandom_range(0, 99) == 0);
            step("random");
        end
        idle_inputs();
        step("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
